lcd_cmd_sequencer: RTL and testbench

Upstream command issuer for the LCD image-processing controller. Buffers a host-supplied command stream in a small FIFO and presents commands one at a time on the controller's `cmd`/`cmd_valid` port, obeying its `busy` handshake. Tracks the terminal WRITE command and flags sequence completion when the controller raises `done`.

---
 rtl/lcd_pkg.sv | 31 +++
 rtl/lcd_cmd_fifo.sv | 69 ++++++
 rtl/lcd_cmd_sequencer.sv | 136 +++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command sequencer.
//   - Command codes understood by the LCD image-processing controller.
//   - CMD_LAST: highest legal command code; codes above it are dropped.
//   - state_t: encoding of the sequencer FSM.
package lcd_pkg;

   localparam int WRITE       = 0;
   localparam int SHIFT_UP    = 1;
   localparam int SHIFT_DOWN  = 2;
   localparam int SHIFT_LEFT  = 3;
   localparam int SHIFT_RIGHT = 4;
   localparam int MAX         = 5;
   localparam int MIN         = 6;
   localparam int AVERAGE     = 7;
   localparam int C_ROTATE    = 8;
   localparam int ROTATE      = 9;
   localparam int MIRROR_X    = 10;
   localparam int MIRROR_Y    = 11;

   localparam int CMD_LAST    = 11;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_WAIT_FREE = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_FINISH    = 3'd5
   } state_t;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO for the LCD sequencer.
// Ports:
//   clk, reset        clock, synchronous active-high reset (flushes contents)
//   push, push_data   write request and data; ignored when full
//   pop               read request; ignored when empty
//   full, empty       occupancy flags derived from count
//   count             current number of entries
//   head              oldest entry (valid when !empty)
// A push and pop in the same cycle leave count unchanged. Because empty is
// derived from the registered count, an entry pushed into an empty FIFO only
// becomes visible on the following cycle.
module lcd_cmd_fifo
   import lcd_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CMD_W = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [CMD_W-1:0]         push_data,
   input  logic                     pop,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [CMD_W-1:0]         head
);

   localparam int AW = $clog2(DEPTH);

   logic [CMD_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Upstream command issuer for the LCD image-processing controller.
// Buffers host commands in a FIFO and hands them to the controller one at a
// time using its busy handshake; flags completion after the terminal WRITE.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   host_cmd/valid/ready    host command stream (ready/valid handshake)
//   lcd_busy, lcd_done      controller status
//   cmd, cmd_valid          registered command strobe to the controller
//   fifo_count              FIFO occupancy
//   issued_cnt              commands accepted by the controller (saturating)
//   seq_done                sticky: WRITE completed
//   err_illegal             sticky: an out-of-range command was dropped
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | wait for a queued command and a free controller
// ISSUE      | cmd_valid high until the controller is free to capture it
// WAIT_BUSY  | wait for the controller to start working on the command
// WAIT_FREE  | wait for a non-terminal command to finish
// WAIT_DONE  | WRITE in flight, wait for lcd_done
// FINISH     | sequence complete, absorbing until reset
module lcd_cmd_sequencer
   import lcd_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CMD_W = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [CMD_W-1:0]         host_cmd,
   input  logic                     host_valid,
   output logic                     host_ready,
   input  logic                     lcd_busy,
   input  logic                     lcd_done,
   output logic [CMD_W-1:0]         cmd,
   output logic                     cmd_valid,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [7:0]               issued_cnt,
   output logic                     seq_done,
   output logic                     err_illegal
);

   state_t           state;
   logic             write_seen;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CMD_W-1:0] fifo_head;
   logic             host_accept;
   logic             cmd_legal;
   logic             fifo_push;
   logic             fifo_pop;

   // Once the WRITE has been queued nothing further may follow it.
   assign host_ready  = !fifo_full && !write_seen && !seq_done;
   assign host_accept = host_valid && host_ready;
   assign cmd_legal   = (host_cmd <= CMD_W'(CMD_LAST));
   assign fifo_push   = host_accept && cmd_legal;
   assign fifo_pop    = (state == S_IDLE) && !fifo_empty && !lcd_busy;

   lcd_cmd_fifo #(
      .DEPTH (DEPTH),
      .CMD_W (CMD_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (host_cmd),
      .pop       (fifo_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         cmd         <= '0;
         cmd_valid   <= 1'b0;
         issued_cnt  <= '0;
         seq_done    <= 1'b0;
         err_illegal <= 1'b0;
         write_seen  <= 1'b0;
      end else begin
         // Illegal commands still complete the handshake but are discarded.
         if (host_accept && !cmd_legal) begin
            err_illegal <= 1'b1;
         end
         if (fifo_push && (host_cmd == CMD_W'(WRITE))) begin
            write_seen <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (fifo_pop) begin
                  cmd       <= fifo_head;
                  cmd_valid <= 1'b1;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!lcd_busy) begin
                  cmd_valid <= 1'b0;
                  if (issued_cnt != 8'hFF) begin
                     issued_cnt <= issued_cnt + 8'd1;
                  end
                  state <= S_WAIT_BUSY;
               end
            end
            S_WAIT_BUSY: begin
               if (lcd_busy) begin
                  state <= (cmd == CMD_W'(WRITE)) ? S_WAIT_DONE : S_WAIT_FREE;
               end
            end
            S_WAIT_FREE: begin
               if (!lcd_busy) begin
                  state <= S_IDLE;
               end
            end
            S_WAIT_DONE: begin
               if (lcd_done) begin
                  seq_done <= 1'b1;
                  state    <= S_FINISH;
               end
            end
            S_FINISH: begin
               cmd_valid <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed self-checking bench for lcd_cmd_sequencer, with a small
// bus-functional model of the LCD controller that can be switched in or
// replaced by a manually driven busy line.
module tb_lcd_cmd_sequencer;
   import lcd_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] host_cmd = 4'd0;
   logic       host_valid = 1'b0;
   logic       host_ready;
   logic       lcd_busy;
   logic       lcd_done;
   logic [3:0] cmd;
   logic       cmd_valid;
   logic [3:0] fifo_count;
   logic [7:0] issued_cnt;
   logic       seq_done;
   logic       err_illegal;

   int errors = 0;
   int checks = 0;

   // controller model
   logic       bfm_en = 1'b0;
   logic       man_busy = 1'b1;
   logic [6:0] busy_left = 7'd0;
   logic [6:0] wtimer = 7'd0;
   logic [3:0] cap_log [64];
   int         cap_n = 0;

   assign lcd_busy = bfm_en ? (busy_left != 7'd0) : man_busy;
   assign lcd_done = bfm_en && (wtimer == 7'd1);

   always #5 clk = ~clk;

   lcd_cmd_sequencer #(.DEPTH(8), .CMD_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .host_cmd    (host_cmd),
      .host_valid  (host_valid),
      .host_ready  (host_ready),
      .lcd_busy    (lcd_busy),
      .lcd_done    (lcd_done),
      .cmd         (cmd),
      .cmd_valid   (cmd_valid),
      .fifo_count  (fifo_count),
      .issued_cnt  (issued_cnt),
      .seq_done    (seq_done),
      .err_illegal (err_illegal)
   );

   // Captures a command whenever the strobe is seen while free. Single-cycle
   // ops hold busy 1 cycle, AVERAGE 2, WRITE stays busy and raises done in
   // the 66th cycle after the capture edge.
   always @(posedge clk) begin
      if (!bfm_en) begin
         busy_left <= 7'd0;
         wtimer    <= 7'd0;
      end else begin
         if (wtimer != 7'd0) wtimer <= wtimer - 7'd1;
         if (busy_left != 7'd0) begin
            busy_left <= busy_left - 7'd1;
         end else if (cmd_valid) begin
            cap_log[cap_n[5:0]] <= cmd;
            cap_n <= cap_n + 1;
            if (cmd == 4'd7) begin
               busy_left <= 7'd2;
            end else if (cmd == 4'd0) begin
               busy_left <= 7'd67;
               wtimer    <= 7'd67;
            end else begin
               busy_left <= 7'd1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [3:0] c);
      host_cmd   = c;
      host_valid = 1'b1;
      tick();
      host_valid = 1'b0;
   endtask

   task automatic wait_caps(input int target);
      for (int i = 0; i < 400 && cap_n < target; i++) tick();
      chk("capture_count", 32'(cap_n), 32'(target));
   endtask

   initial begin
      logic [3:0] burst [8];
      int base;
      burst = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd10, 4'd11, 4'd6, 4'd8};

      // reset with controller busy (image load)
      tick();
      tick();
      chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("rst_cmd", 32'(cmd), 32'd0);
      chk("rst_fifo_count", 32'(fifo_count), 32'd0);
      chk("rst_issued", 32'(issued_cnt), 32'd0);
      chk("rst_seq_done", 32'(seq_done), 32'd0);
      chk("rst_err", 32'(err_illegal), 32'd0);
      reset = 1'b0;
      tick();
      chk("ready_after_rst", 32'(host_ready), 32'd1);

      // test 1: single command held back by busy, then issued
      push(4'd3);
      chk("t1_count", 32'(fifo_count), 32'd1);
      tick();
      tick();
      chk("t1_no_issue_busy", 32'(cmd_valid), 32'd0);
      bfm_en = 1'b1;
      base = cap_n;
      tick();
      chk("t1_valid", 32'(cmd_valid), 32'd1);
      chk("t1_cmd", 32'(cmd), 32'd3);
      tick();
      chk("t1_valid_drop", 32'(cmd_valid), 32'd0);
      chk("t1_issued", 32'(issued_cnt), 32'd1);
      chk("t1_busy_up", 32'(lcd_busy), 32'd1);
      tick();
      chk("t1_not_idle_yet", 32'(dut.state), 32'(S_WAIT_FREE));
      tick();
      chk("t1_idle", 32'(dut.state), 32'(S_IDLE));
      chk("t1_cap", 32'(cap_log[base[5:0]]), 32'd3);

      // test 2: fill FIFO while busy, overflow rejected, drain in order
      bfm_en   = 1'b0;
      man_busy = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) push(burst[i]);
      chk("t2_count_full", 32'(fifo_count), 32'd8);
      chk("t2_ready_full", 32'(host_ready), 32'd0);
      push(4'd5);
      chk("t2_ninth_rejected", 32'(fifo_count), 32'd8);
      base   = cap_n;
      bfm_en = 1'b1;
      wait_caps(base + 8);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t2_order_%0d", i), 32'(cap_log[6'(base + i)]), 32'(burst[i]));
      end
      tick();
      tick();
      tick();
      chk("t2_issued", 32'(issued_cnt), 32'd9);
      chk("t2_idle", 32'(dut.state), 32'(S_IDLE));
      chk("t2_empty", 32'(fifo_count), 32'd0);

      // test 3: illegal command dropped, next legal accepted
      bfm_en   = 1'b0;
      man_busy = 1'b1;
      tick();
      push(4'd13);
      chk("t3_err", 32'(err_illegal), 32'd1);
      chk("t3_count", 32'(fifo_count), 32'd0);
      chk("t3_ready", 32'(host_ready), 32'd1);
      push(4'd5);
      chk("t3_legal_push", 32'(fifo_count), 32'd1);

      // test 5: simultaneous push and pop at count 1
      base       = cap_n;
      bfm_en     = 1'b1;
      host_cmd   = 4'd2;
      host_valid = 1'b1;
      tick();
      host_valid = 1'b0;
      chk("t5_count", 32'(fifo_count), 32'd1);
      chk("t5_valid", 32'(cmd_valid), 32'd1);
      chk("t5_cmd", 32'(cmd), 32'd5);
      wait_caps(base + 2);
      chk("t5_order0", 32'(cap_log[6'(base)]), 32'd5);
      chk("t5_order1", 32'(cap_log[6'(base + 1)]), 32'd2);
      tick();
      tick();
      tick();
      chk("t5_issued", 32'(issued_cnt), 32'd11);
      chk("t5_err_sticky", 32'(err_illegal), 32'd1);

      // test 4: AVERAGE then WRITE, completion
      bfm_en = 1'b0;
      man_busy = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      bfm_en = 1'b1;
      tick();
      base = cap_n;
      push(4'd7);
      push(4'd0);
      chk("t4_ready_after_write", 32'(host_ready), 32'd0);
      for (int i = 0; i < 300 && !lcd_done; i++) tick();
      chk("t4_done_seen", 32'(lcd_done), 32'd1);
      chk("t4_seq_done_before", 32'(seq_done), 32'd0);
      tick();
      chk("t4_seq_done", 32'(seq_done), 32'd1);
      chk("t4_issued", 32'(issued_cnt), 32'd2);
      chk("t4_finish", 32'(dut.state), 32'(S_FINISH));
      chk("t4_ready", 32'(host_ready), 32'd0);
      chk("t4_cap0", 32'(cap_log[6'(base)]), 32'd7);
      chk("t4_cap1", 32'(cap_log[6'(base + 1)]), 32'd0);
      tick();
      chk("t4_valid_low", 32'(cmd_valid), 32'd0);
      chk("t4_sticky", 32'(seq_done), 32'd1);

      // test 6: reset during WAIT_FREE with 3 queued
      bfm_en   = 1'b0;
      man_busy = 1'b1;
      reset    = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("t6_seq_done_clr", 32'(seq_done), 32'd0);
      chk("t6_ready", 32'(host_ready), 32'd1);
      push(4'd13);
      push(4'd4);
      push(4'd1);
      push(4'd2);
      push(4'd3);
      chk("t6_count4", 32'(fifo_count), 32'd4);
      man_busy = 1'b0;
      tick();
      chk("t6_valid", 32'(cmd_valid), 32'd1);
      chk("t6_cmd", 32'(cmd), 32'd4);
      tick();
      man_busy = 1'b1;
      tick();
      chk("t6_wait_free", 32'(dut.state), 32'(S_WAIT_FREE));
      chk("t6_count3", 32'(fifo_count), 32'd3);
      chk("t6_err_pre", 32'(err_illegal), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_count_flush", 32'(fifo_count), 32'd0);
      chk("t6_valid_clr", 32'(cmd_valid), 32'd0);
      chk("t6_idle", 32'(dut.state), 32'(S_IDLE));
      chk("t6_err_clr", 32'(err_illegal), 32'd0);
      chk("t6_issued_clr", 32'(issued_cnt), 32'd0);
      chk("t6_cmd_clr", 32'(cmd), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
